// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use and branch-compare stalls, IF/ID flush.
// Optional stall/flush event counters are built only when HAZARD_PERF_EN is defined.
module hazard_stall_ctrl #(
    parameter int MAX_STALL = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  rs_address_ID,
    input  logic [4:0]  rt_address_ID,
    input  logic        UsesRt_ID,
    input  logic        BranchCmp_ID,
    input  logic        Jump_ID,
    input  logic        JR_ID,
    input  logic        BranchTaken_ID,
    input  logic [1:0]  MemRead_EX,
    input  logic        RegWrite_EX,
    input  logic [4:0]  WriteReg_EX,
    input  logic [1:0]  MemRead_MEM,
    input  logic [4:0]  WriteReg_MEM,
    output logic        ControlMuxSig,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic [31:0] StallCycles,
    output logic [15:0] FlushCount
);
    localparam int CW = $clog2(MAX_STALL + 1);

    typedef enum logic {S_RUN, S_STALL} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [CW-1:0] w_need;
    logic          w_ld_ex, w_m_ex, w_m_mem, w_stall;

    function automatic logic f_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    always_comb begin
        w_ld_ex = |MemRead_EX;
        w_m_ex  = f_match(WriteReg_EX, rs_address_ID, rt_address_ID, UsesRt_ID);
        w_m_mem = f_match(WriteReg_MEM, rs_address_ID, rt_address_ID, UsesRt_ID);
        w_need  = '0;
        // A load feeding a branch compare must reach WB-forwarding range: two bubbles
        if (w_ld_ex && w_m_ex && BranchCmp_ID)
            w_need = CW'(2);
        else if ((w_ld_ex && w_m_ex) ||
                 (BranchCmp_ID && RegWrite_EX && w_m_ex) ||
                 (BranchCmp_ID && (|MemRead_MEM) && w_m_mem))
            w_need = CW'(1);
        w_stall = (r_state == S_STALL) || (w_need != '0);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        case (r_state)
            S_RUN: begin
                if (w_need != '0) begin
                    w_cnt_nxt = CW'(w_need - 1'b1);
                    if (w_cnt_nxt != '0)
                        w_next = S_STALL;
                end
            end
            S_STALL: begin
                w_cnt_nxt = CW'(r_cnt - 1'b1);
                if (r_cnt == CW'(1))
                    w_next = S_RUN;
            end
            default: begin
                w_next    = S_RUN;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // Stall beats flush: the jump/branch stays in ID and flushes on its first free cycle
    always_comb begin
        ControlMuxSig = 1'b0;
        PCWrite       = 1'b0;
        IFIDWrite     = 1'b0;
        IFIDFlush     = 1'b0;
        if (Reset && !w_stall) begin
            ControlMuxSig = 1'b1;
            PCWrite       = 1'b1;
            IFIDWrite     = 1'b1;
            IFIDFlush     = Jump_ID || JR_ID || BranchTaken_ID;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!ControlMuxSig && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (IFIDFlush && (r_flush_count != '1))
                r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign StallCycles = r_stall_cycles;
    assign FlushCount  = r_flush_count;
`else
    assign StallCycles = '0;
    assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: expected outputs queued per driven cycle, checked at the falling edge.
// Counter expectations follow HAZARD_PERF_EN the same way the design does.
module tb_hazard_stall_ctrl;
    logic        Clk, Reset;
    logic [4:0]  rs_address_ID, rt_address_ID, WriteReg_EX, WriteReg_MEM;
    logic        UsesRt_ID, BranchCmp_ID, Jump_ID, JR_ID, BranchTaken_ID, RegWrite_EX;
    logic [1:0]  MemRead_EX, MemRead_MEM;
    logic        ControlMuxSig, PCWrite, IFIDWrite, IFIDFlush;
    logic [31:0] StallCycles;
    logic [15:0] FlushCount;

    hazard_stall_ctrl #(.MAX_STALL(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .rs_address_ID(rs_address_ID), .rt_address_ID(rt_address_ID),
        .UsesRt_ID(UsesRt_ID), .BranchCmp_ID(BranchCmp_ID), .Jump_ID(Jump_ID),
        .JR_ID(JR_ID), .BranchTaken_ID(BranchTaken_ID),
        .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX), .WriteReg_EX(WriteReg_EX),
        .MemRead_MEM(MemRead_MEM), .WriteReg_MEM(WriteReg_MEM),
        .ControlMuxSig(ControlMuxSig), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IFIDFlush(IFIDFlush), .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        bit          rst_n;
        logic        cm, pcw, ifw, fl;
        logic [31:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_sc = '0;
    logic [15:0] m_fc = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rs_address_ID = 5'd0; rt_address_ID = 5'd0; UsesRt_ID = 1'b0;
        BranchCmp_ID = 1'b0; Jump_ID = 1'b0; JR_ID = 1'b0; BranchTaken_ID = 1'b0;
        MemRead_EX = 2'b00; RegWrite_EX = 1'b0; WriteReg_EX = 5'd0;
        MemRead_MEM = 2'b00; WriteReg_MEM = 5'd0;
    endtask

    // Push the expectation for the cycle just driven, then pop and compare mid-cycle
    task automatic cyc(input string tag, input logic cm, input logic pcw,
                       input logic ifw, input logic fl);
        exp_t e;
        e.tag = tag; e.rst_n = Reset;
        e.cm = cm; e.pcw = pcw; e.ifw = ifw; e.fl = fl;
`ifdef HAZARD_PERF_EN
        e.sc = m_sc; e.fc = m_fc;
`else
        e.sc = '0; e.fc = '0;
`endif
        sb.push_back(e);
        @(negedge Clk);
        e = sb.pop_front();
        chk({e.tag, ".cms"},   {31'b0, ControlMuxSig}, {31'b0, e.cm});
        chk({e.tag, ".pcw"},   {31'b0, PCWrite},       {31'b0, e.pcw});
        chk({e.tag, ".ifidw"}, {31'b0, IFIDWrite},     {31'b0, e.ifw});
        chk({e.tag, ".flush"}, {31'b0, IFIDFlush},     {31'b0, e.fl});
        chk({e.tag, ".stallc"}, StallCycles, e.sc);
        chk({e.tag, ".flushc"}, {16'b0, FlushCount}, {16'b0, e.fc});
        if (!e.rst_n) begin
            m_sc = '0; m_fc = '0;
        end else begin
            if (!e.cm && (m_sc != '1)) m_sc = m_sc + 32'd1;
            if (e.fl && (m_fc != '1))  m_fc = m_fc + 16'd1;
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        Reset = 1'b0;
        idle();
        @(posedge Clk); #1;
        cyc("rst0", 0, 0, 0, 0);
        Reset = 1'b1;
        idle(); cyc("idle", 1, 1, 1, 0);

        // Load-use on rs: one bubble, then the load has moved to MEM
        MemRead_EX = 2'b01; WriteReg_EX = 5'd8; rs_address_ID = 5'd8;
        cyc("lu", 0, 0, 0, 0);
        idle(); MemRead_MEM = 2'b01; WriteReg_MEM = 5'd8; rs_address_ID = 5'd8;
        cyc("lu_after", 1, 1, 1, 0);

        // Load then beq on rt: two bubbles, second ignores inputs
        idle(); MemRead_EX = 2'b01; WriteReg_EX = 5'd9; rt_address_ID = 5'd9;
        UsesRt_ID = 1'b1; BranchCmp_ID = 1'b1;
        cyc("lb1", 0, 0, 0, 0);
        idle(); Jump_ID = 1'b1;
        cyc("lb2", 0, 0, 0, 0);
        idle(); cyc("lb_after", 1, 1, 1, 0);

        // Register 0 and rt gating
        idle(); MemRead_EX = 2'b10; WriteReg_EX = 5'd0; rs_address_ID = 5'd0;
        cyc("r0", 1, 1, 1, 0);
        idle(); MemRead_EX = 2'b01; WriteReg_EX = 5'd5; rt_address_ID = 5'd5;
        rs_address_ID = 5'd3; UsesRt_ID = 1'b0;
        cyc("rt_gate", 1, 1, 1, 0);
        UsesRt_ID = 1'b1;
        cyc("rt_use", 0, 0, 0, 0);
        idle(); cyc("rt_after", 1, 1, 1, 0);

        // ALU result feeding a branch compare, and a load in MEM feeding one
        idle(); BranchCmp_ID = 1'b1; RegWrite_EX = 1'b1; WriteReg_EX = 5'd4; rs_address_ID = 5'd4;
        cyc("alu_br", 0, 0, 0, 0);
        idle(); BranchCmp_ID = 1'b0; RegWrite_EX = 1'b1; WriteReg_EX = 5'd4; rs_address_ID = 5'd4;
        cyc("alu_nobr", 1, 1, 1, 0);
        idle(); BranchCmp_ID = 1'b1; MemRead_MEM = 2'b11; WriteReg_MEM = 5'd12; rs_address_ID = 5'd12;
        cyc("mem_br", 0, 0, 0, 0);
        idle(); cyc("mem_after", 1, 1, 1, 0);

        // Jump coinciding with load-use: stall first, flush next cycle
        idle(); Jump_ID = 1'b1; MemRead_EX = 2'b01; WriteReg_EX = 5'd7; rs_address_ID = 5'd7;
        cyc("jmp_st", 0, 0, 0, 0);
        idle(); Jump_ID = 1'b1;
        cyc("jmp_fl", 1, 1, 1, 1);
        idle(); JR_ID = 1'b1;
        cyc("jr_fl", 1, 1, 1, 1);
        idle(); BranchTaken_ID = 1'b1;
        cyc("bt_fl", 1, 1, 1, 1);
        idle(); cyc("fl_after", 1, 1, 1, 0);

`ifdef HAZARD_PERF_EN
        // Saturation: preload both counters to all-ones, then stall and flush
        idle(); MemRead_EX = 2'b01; WriteReg_EX = 5'd8; rs_address_ID = 5'd8;
        force dut.r_stall_cycles = '1;
        force dut.r_flush_count  = '1;
        #1;
        release dut.r_stall_cycles;
        release dut.r_flush_count;
        m_sc = '1; m_fc = '1;
        cyc("sat_st", 0, 0, 0, 0);
        idle(); Jump_ID = 1'b1;
        cyc("sat_fl", 1, 1, 1, 1);
        idle(); cyc("sat_hold", 1, 1, 1, 0);
`endif

        // Reset during the second cycle of a two-cycle stall
        idle(); MemRead_EX = 2'b01; WriteReg_EX = 5'd9; rs_address_ID = 5'd9; BranchCmp_ID = 1'b1;
        cyc("rs_s1", 0, 0, 0, 0);
        Reset = 1'b0;
        cyc("rs_s2", 0, 0, 0, 0);
        idle(); Jump_ID = 1'b1;
        cyc("rs_hold", 0, 0, 0, 0);
        Reset = 1'b1;
        idle(); cyc("rs_run", 1, 1, 1, 0);
        MemRead_EX = 2'b01; WriteReg_EX = 5'd6; rs_address_ID = 5'd6;
        cyc("rs_fresh", 0, 0, 0, 0);
        idle(); cyc("rs_end", 1, 1, 1, 0);
        idle(); cyc("final", 1, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

- Hazard and stall controller for the 5-stage MIPS pipeline.
- Watches the instruction in ID against the producers in EX and MEM.
- Drives the bubble select (`ControlMuxSig`) into the ID/EX register, plus PC and IF/ID write enables and the IF/ID flush.
- Sequences multi-cycle stalls with a small FSM and optionally counts stall and flush events.

## Interface
Parameters:
- `MAX_STALL`, 2: largest stall length in cycles; sets the width of the down-counter.

Ports:
- `Clk` in 1: rising-edge clock.
- `Reset` in 1: synchronous, active-low reset.
- `rs_address_ID` in 5: rs field of the instruction in ID.
- `rt_address_ID` in 5: rt field of the instruction in ID.
- `UsesRt_ID` in 1: ID instruction reads rt as a source.
- `BranchCmp_ID` in 1: ID instruction compares registers in ID (beq, bne, JR).
- `Jump_ID` in 1: ID holds j or jal.
- `JR_ID` in 1: ID holds jr.
- `BranchTaken_ID` in 1: ID branch resolved taken.
- `MemRead_EX` in 2: nonzero means EX holds a load.
- `RegWrite_EX` in 1: EX instruction writes a register.
- `WriteReg_EX` in 5: destination register in EX, after the RegDst mux.
- `MemRead_MEM` in 2: nonzero means MEM holds a load.
- `WriteReg_MEM` in 5: destination register in MEM.
- `ControlMuxSig` out 1: 1 = pass ID controls to EX; 0 = insert bubble.
- `PCWrite` out 1: PC load enable.
- `IFIDWrite` out 1: IF/ID register load enable.
- `IFIDFlush` out 1: clear IF/ID to a nop on the next edge.
- `StallCycles` out 32: bubble cycles inserted, saturating.
- `FlushCount` out 16: flushes issued, saturating.

## Operation
Match rules:
- A match `m(r)` is `r != 0 && (r == rs_address_ID || (UsesRt_ID && r == rt_address_ID))`.
- Register 0 never matches.

Stall need `N`, evaluated only in RUN, highest priority first:
- `N=2`: `MemRead_EX != 0 && m(WriteReg_EX) && BranchCmp_ID`.
- `N=1`: `MemRead_EX != 0 && m(WriteReg_EX)` (load-use).
- `N=1`: `BranchCmp_ID && RegWrite_EX && m(WriteReg_EX)`.
- `N=1`: `BranchCmp_ID && MemRead_MEM != 0 && m(WriteReg_MEM)`.
- `N=0`: otherwise.

FSM states:
- RUN:
  - `N>0`: drive stall outputs this cycle, load `cnt = N-1`. Go to STALL if `cnt != 0`; otherwise stay in RUN.
  - `N=0`: normal flow, all enables high.
- STALL:
  - Drive stall outputs unconditionally; hazard detection is masked.
  - Decrement `cnt`; at `cnt == 1`, next state is RUN.

Stall outputs: `ControlMuxSig=0`, `PCWrite=0`, `IFIDWrite=0`, `IFIDFlush=0`.

Flush:
- `IFIDFlush=1` for one cycle when `(Jump_ID || JR_ID || BranchTaken_ID)` and no stall is driven that cycle.
- If a stall and a flush request coincide, the stall wins and no flush is issued.
- The instruction stays in ID, so the flush issues on the first non-stall cycle.

Counters:
- `StallCycles` increments on every cycle with `ControlMuxSig=0` outside reset.
- `FlushCount` increments on every cycle with `IFIDFlush=1`.
- Both saturate at all-ones.

## Timing
- Stall outputs are combinational from inputs plus registered state: a hazard present in cycle t bubbles the ID/EX edge at the end of cycle t (zero latency).
- `state`, `cnt` and the counters update on the rising edge of `Clk`.

Reset (`Reset==0` at an edge):
- `state=RUN`, `cnt=0`, `StallCycles=0`, `FlushCount=0`.
- While `Reset==0`, combinational outputs are forced to `ControlMuxSig=0`, `PCWrite=0`, `IFIDWrite=0`, `IFIDFlush=0`.
- Reset asserted during STALL aborts the stall; the first cycle after release is RUN with a fresh evaluation.

Stall lengths:
- `N=2` gives exactly 2 consecutive bubble cycles.
- `N=1` gives exactly 1, with no re-detection on the following cycle.

## Configuration
- `HAZARD_PERF_EN` defined: `StallCycles` and `FlushCount` are implemented as above.
- `HAZARD_PERF_EN` undefined: both outputs are tied to 0 and no counter flops exist. Stall and flush behaviour is identical.

## Test plan
- **Load-use:** `MemRead_EX=2'b01`, `WriteReg_EX=8`, `rs_address_ID=8`, `BranchCmp_ID=0` -> exactly one cycle with `ControlMuxSig=0`, `PCWrite=0`, `IFIDWrite=0`, then all 1; `StallCycles=1`.
- **Load then beq:** `MemRead_EX=2'b01`, `WriteReg_EX=9`, `rt_address_ID=9`, `UsesRt_ID=1`, `BranchCmp_ID=1` -> 2 bubble cycles ignoring input changes in cycle 2; `StallCycles=2`.
- **Register 0 and rt gating:** `WriteReg_EX=0`, or a rt-only match with `UsesRt_ID=0` -> no stall.
- **Jump coinciding with stall:** `Jump_ID=1` in the same cycle as a load-use stall -> cycle 1 stalls with `IFIDFlush=0`; cycle 2 has `IFIDFlush=1`; `FlushCount=1`.
- **Reset mid-stall:** drive `Reset=0` during the second cycle of an `N=2` stall -> next cycle is RUN, `cnt=0`, counters 0, all outputs forced 0 while held low.
- **Saturation (`HAZARD_PERF_EN` defined):** force `StallCycles` to all-ones, apply a stall -> value holds at all-ones. With the macro undefined, both counters read 0 throughout.
